// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the pipeline control and the hazard scoreboard.
// The pipeline holds the master modport; the scoreboard holds the slave.
interface hazard_scoreboard_if #(
    parameter int FW = 2
);
    logic [31:0]   instr_d;
    logic          issue;
    logic          flush;
    logic          stall;
    logic [FW-1:0] fwd_a;
    logic [FW-1:0] fwd_b;
    logic          load_a;
    logic          load_b;
    logic [15:0]   stall_cnt;

    modport master (
        output instr_d, issue, flush,
        input  stall, fwd_a, fwd_b, load_a, load_b, stall_cnt
    );

    modport slave (
        input  instr_d, issue, flush,
        output stall, fwd_a, fwd_b, load_a, load_b, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destinations feeding decode.
// It produces forwarding distances, from-load flags, load-use stalls and a stall counter.
module hazard_scoreboard #(
    parameter int DEPTH    = 3,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int FW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    hazard_scoreboard_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef struct packed {
        logic          not_ready;
        logic [FW-1:0] fwd;
        logic          load;
    } match_t;

    logic [DEPTH:1] sb_valid;
    logic [DEPTH:1] sb_load;
    logic [4:0]     sb_dest [1:DEPTH];
    logic [15:0]    stall_cnt_q;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       has_dest;
    logic [4:0] dest;
    logic       is_load;
    logic       use_rs;
    logic       use_rt;
    match_t     match_a;
    match_t     match_b;
    logic       stall_int;

    assign opcode = bus.instr_d[31:26];
    assign rs     = bus.instr_d[25:21];
    assign rt     = bus.instr_d[20:16];
    assign rd     = bus.instr_d[15:11];

    always_comb begin
        has_dest = 1'b0;
        dest     = 5'd0;
        is_load  = 1'b0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                has_dest = 1'b1;
                dest     = rd;
                use_rs   = 1'b1;
                use_rt   = 1'b1;
            end
            OP_LW: begin
                has_dest = 1'b1;
                dest     = rt;
                is_load  = 1'b1;
                use_rs   = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // Scanning oldest to youngest lets the smallest matching distance overwrite the rest.
    function automatic match_t lookup(input logic [4:0] src, input logic used);
        match_t m;
        m = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (used && (src != 5'd0) && sb_valid[k] && (sb_dest[k] == src)) begin
                m.fwd       = FW'(k);
                m.load      = sb_load[k];
                m.not_ready = (k < (sb_load[k] ? LOAD_LAT : ALU_LAT));
            end
        end
        return m;
    endfunction

    always_comb begin
        match_a = lookup(rs, use_rs);
        match_b = lookup(rt, use_rt);
    end

    assign stall_int     = bus.issue & ~bus.flush & (match_a.not_ready | match_b.not_ready);
    assign bus.stall     = stall_int;
    assign bus.fwd_a     = match_a.fwd;
    assign bus.fwd_b     = match_b.fwd;
    assign bus.load_a    = match_a.load;
    assign bus.load_b    = match_b.load;
    assign bus.stall_cnt = stall_cnt_q;

    // The scoreboard ages every cycle; stalled or flushed slots enter as bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid    <= '0;
            stall_cnt_q <= 16'd0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_load[k]  <= sb_load[k-1];
                sb_dest[k]  <= sb_dest[k-1];
            end
            sb_valid[1] <= bus.issue & ~bus.flush & ~stall_int & has_dest;
            sb_load[1]  <= is_load;
            sb_dest[1]  <= dest;
            if (stall_int && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a vector table on the default build plus
// hand sequences for saturation (deep build) and reset during a stall.
module tb_hazard_scoreboard;
    localparam logic [31:0] I_A  = 32'h00221820; // add $3,$1,$2
    localparam logic [31:0] I_B  = 32'h00632020; // add $4,$3,$3
    localparam logic [31:0] I_L  = 32'h8C250000; // lw  $5,0($1)
    localparam logic [31:0] I_U  = 32'h00A03020; // add $6,$5,$0
    localparam logic [31:0] I_N  = 32'h00000000;
    localparam logic [31:0] I_C  = 32'h00804820; // add $9,$4,$0
    localparam logic [31:0] I_Z  = 32'h00220020; // add $0,$1,$2
    localparam logic [31:0] I_Z2 = 32'h00002020; // add $4,$0,$0
    localparam logic [31:0] I_S  = 32'hAC270000; // sw  $7,0($1)
    localparam logic [31:0] I_E  = 32'h00E74020; // add $8,$7,$7
    localparam logic [31:0] I_R6 = 32'h00C00020; // add $0,$6,$0
    localparam logic [31:0] I_J  = 32'h08A50000; // j (no operands)
    localparam logic [31:0] I_W  = 32'h00055020; // add $10,$0,$5
    localparam logic [31:0] I_LL = 32'h8CA50000; // lw  $5,0($5)

    typedef struct {
        logic [31:0] instr;
        logic        issue;
        logic        flush;
        logic        stall;
        logic        chk_fwd;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        la;
        logic        lb;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.FW(2)) bus ();
    hazard_scoreboard_if #(.FW(4)) sat_bus ();

    hazard_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    hazard_scoreboard #(.DEPTH(15), .ALU_LAT(1), .LOAD_LAT(15), .FW(4)) sat_dut (
        .clk (clk),
        .rst (rst),
        .bus (sat_bus)
    );

    task automatic addv(input logic [31:0] instr, input logic issue, input logic flush,
                        input logic stall, input logic chk_fwd, input logic [1:0] fa,
                        input logic [1:0] fb, input logic la, input logic lb,
                        input logic [15:0] cnt);
        vec_t v;
        v.instr = instr; v.issue = issue; v.flush = flush; v.stall = stall;
        v.chk_fwd = chk_fwd; v.fa = fa; v.fb = fb; v.la = la; v.lb = lb; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic issue, input logic flush);
        bus.instr_d = instr;
        bus.issue   = issue;
        bus.flush   = flush;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, actual, expected);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.instr_d = 32'h0; bus.issue = 1'b0; bus.flush = 1'b0;
        sat_bus.instr_d = 32'h0; sat_bus.issue = 1'b0; sat_bus.flush = 1'b0;

        //   instr  iss fl  stall chk  fa    fb    la  lb  cnt
        addv(I_A,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd0);  // 0
        addv(I_B,   1, 0,  0,   1,   2'd1, 2'd1, 0,  0,  16'd0);  // 1 back-to-back
        addv(I_L,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd0);  // 2
        addv(I_U,   1, 0,  1,   0,   2'd0, 2'd0, 0,  0,  16'd0);  // 3 load-use stall
        addv(I_U,   1, 0,  0,   1,   2'd2, 2'd0, 1,  0,  16'd1);  // 4 load forwarded
        addv(I_A,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 5
        addv(I_A,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 6
        addv(I_N,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 7
        addv(I_B,   1, 0,  0,   1,   2'd2, 2'd2, 0,  0,  16'd1);  // 8 youngest wins
        addv(I_N,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 9
        addv(I_N,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 10
        addv(I_N,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 11
        addv(I_B,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 12 aged out
        addv(I_N,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 13
        addv(I_N,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 14
        addv(I_C,   1, 0,  0,   1,   2'd3, 2'd0, 0,  0,  16'd1);  // 15 distance DEPTH
        addv(I_Z,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 16
        addv(I_Z2,  1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 17 $0 never matches
        addv(I_S,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 18
        addv(I_E,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 19 sw has no dest
        addv(I_L,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 20
        addv(I_U,   1, 1,  0,   0,   2'd0, 2'd0, 0,  0,  16'd1);  // 21 flush beats stall
        addv(I_R6,  1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 22 flushed slot is a bubble
        addv(I_U,   0, 0,  0,   1,   2'd3, 2'd0, 1,  0,  16'd1);  // 23
        addv(I_L,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 24
        addv(I_U,   0, 0,  0,   0,   2'd0, 2'd0, 0,  0,  16'd1);  // 25 no issue, no stall
        addv(I_U,   1, 0,  0,   1,   2'd2, 2'd0, 1,  0,  16'd1);  // 26
        addv(I_L,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 27
        addv(I_J,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 28 other opcode
        addv(I_W,   1, 0,  0,   1,   2'd0, 2'd2, 0,  1,  16'd1);  // 29 rt from load
        addv(I_L,   1, 0,  0,   1,   2'd0, 2'd0, 0,  0,  16'd1);  // 30
        addv(I_W,   1, 0,  1,   0,   2'd0, 2'd0, 0,  0,  16'd1);  // 31 rt load-use stall
        addv(I_W,   1, 0,  0,   1,   2'd0, 2'd2, 0,  1,  16'd2);  // 32

        rst = 1'b1;
        bus.instr_d = I_U;
        bus.issue   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_stall",  0, 16'(bus.stall),  16'd0);
        checkOutput("reset_fwd_a",  0, 16'(bus.fwd_a),  16'd0);
        checkOutput("reset_fwd_b",  0, 16'(bus.fwd_b),  16'd0);
        checkOutput("reset_load_a", 0, 16'(bus.load_a), 16'd0);
        checkOutput("reset_load_b", 0, 16'(bus.load_b), 16'd0);
        checkOutput("reset_cnt",    0, bus.stall_cnt,   16'd0);
        checkOutput("reset_sat_cnt", 0, sat_bus.stall_cnt, 16'd0);
        advance();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].instr, vecs[i].issue, vecs[i].flush);
            checkOutput("stall", i, 16'(bus.stall), 16'(vecs[i].stall));
            checkOutput("stall_cnt", i, bus.stall_cnt, vecs[i].cnt);
            if (vecs[i].chk_fwd) begin
                checkOutput("fwd_a",  i, 16'(bus.fwd_a),  16'(vecs[i].fa));
                checkOutput("fwd_b",  i, 16'(bus.fwd_b),  16'(vecs[i].fb));
                checkOutput("load_a", i, 16'(bus.load_a), 16'(vecs[i].la));
                checkOutput("load_b", i, 16'(bus.load_b), 16'(vecs[i].lb));
            end
            advance();
        end

        // Deep build: a self-dependent load stalls 14 of every 15 cycles.
        bus.issue = 1'b0;
        bus.flush = 1'b0;
        sat_bus.instr_d = I_LL;
        sat_bus.issue   = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checkOutput("sat_stall", c, 16'(sat_bus.stall), 16'((c % 15) != 0));
            if (c == 15) begin
                checkOutput("sat_fwd_a",  c, 16'(sat_bus.fwd_a),  16'd15);
                checkOutput("sat_load_a", c, 16'(sat_bus.load_a), 16'd1);
            end
            advance();
        end
        @(negedge clk);
        checkOutput("sat_cnt_partial", 30, sat_bus.stall_cnt, 16'd28);
        repeat (72000) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("sat_cnt_saturated", 0, sat_bus.stall_cnt, 16'hFFFF);
        advance();

        // Reset asserted while the default build is stalled on a load-use.
        applyStimulus(I_L, 1'b1, 1'b0);
        checkOutput("rst_seq_stall_before", 0, 16'(bus.stall), 16'd0);
        advance();
        applyStimulus(I_U, 1'b1, 1'b0);
        checkOutput("rst_seq_stall_during", 1, 16'(bus.stall), 16'd1);
        checkOutput("rst_seq_cnt_during",   1, bus.stall_cnt,  16'd2);
        rst = 1'b1;
        advance();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_seq_stall_after",  2, 16'(bus.stall),  16'd0);
        checkOutput("rst_seq_cnt_after",    2, bus.stall_cnt,   16'd0);
        checkOutput("rst_seq_fwd_a_after",  2, 16'(bus.fwd_a),  16'd0);
        checkOutput("rst_seq_fwd_b_after",  2, 16'(bus.fwd_b),  16'd0);
        checkOutput("rst_seq_load_a_after", 2, 16'(bus.load_a), 16'd0);
        checkOutput("rst_seq_sat_cnt",      2, sat_bus.stall_cnt, 16'd0);
        checkOutput("rst_seq_sat_stall",    2, 16'(sat_bus.stall), 16'd0);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
